// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave FSM state type.
// Also provides the little-endian byte-lane decode used by the slave.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ahb_state_t;

  // Byte lanes touched by a transfer; only meaningful for legal size/alignment.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: lanes = 4'b0011 << addr_lo;
      default:    lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_array.sv
// Synchronous 2**MEM_LOG2 x 32 RAM with per-byte write enables.
// The read register holds its word until the next read enable.
module ahb_sram_array #(
  parameter int MEM_LOG2  = 16,
  parameter     INIT_FILE = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          we,
  input  logic [MEM_LOG2-1:0] waddr,
  input  logic [31:0]         wdata,
  input  logic                re,
  input  logic [MEM_LOG2-1:0] raddr,
  output logic [31:0]         rdata
);

  logic [31:0] mem [2**MEM_LOG2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Read returns the pre-write contents on a colliding edge; the slave forwards around that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, byte-lane writes, programmable wait
// states, two-cycle ERROR response and same-word write-to-read forwarding.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int MEM_LOG2    = 16,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  ahb_state_t          state;
  logic [3:0]          wait_cnt;
  logic                hreadyout_q;
  logic [1:0]          hresp_q;

  logic                dp_valid;
  logic                dp_write;
  logic [MEM_LOG2-1:0] dp_addr;
  logic [3:0]          dp_be;

  logic [3:0]          fwd_be;
  logic [31:0]         fwd_data;
  logic [31:0]         ram_rdata;

  logic                take;
  logic                size_err;
  logic                align_err;
  logic                range_err;
  logic                addr_err;
  logic                good;
  logic                commit;
  logic                rd_issue;
  logic                fwd_hit;
  logic [MEM_LOG2-1:0] word_idx;
  logic                unused_inputs;

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign word_idx  = HADDR[MEM_LOG2+1:2];
  assign take      = HSEL & HREADY & HTRANS[1] & hreadyout_q;
  assign size_err  = (HSIZE > HSIZE_WORD);
  assign align_err = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                     ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign range_err = ((HADDR >> (MEM_LOG2 + 2)) != 32'd0);
  assign addr_err  = size_err | align_err | range_err;
  assign good      = take & ~addr_err;

  // A write lands on the edge its data phase completes, which is also the edge a new read may be issued.
  assign commit    = dp_valid & dp_write & hreadyout_q;
  assign rd_issue  = good & ~HWRITE;
  assign fwd_hit   = commit & (dp_addr == word_idx);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      wait_cnt    <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      case (state)
        ST_IDLE, ST_ERR2: begin
          if (take && addr_err) begin
            state       <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else if (good && (WAIT_STATES > 0)) begin
            state       <= ST_WAIT;
            wait_cnt    <= WS_LOAD;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_OKAY;
          end else begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state       <= ST_IDLE;
            hreadyout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state       <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state       <= ST_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  // Address-phase capture; erroring transfers leave dp_valid low so they never write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_be    <= 4'b0000;
    end else if (hreadyout_q) begin
      dp_valid <= good;
      if (good) begin
        dp_write <= HWRITE;
        dp_addr  <= word_idx;
        dp_be    <= byte_lanes(HSIZE, HADDR[1:0]);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fwd_be   <= 4'b0000;
      fwd_data <= 32'd0;
    end else if (rd_issue) begin
      fwd_be   <= fwd_hit ? dp_be : 4'b0000;
      fwd_data <= HWDATA;
    end
  end

  ahb_sram_array #(
    .MEM_LOG2 (MEM_LOG2),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk  (HCLK),
    .rst_n(HRESETn),
    .we   (commit ? dp_be : 4'b0000),
    .waddr(dp_addr),
    .wdata(HWDATA),
    .re   (rd_issue),
    .raddr(word_idx),
    .rdata(ram_rdata)
  );

  always_comb begin
    HRDATA = ram_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fwd_be[i]) begin
        HRDATA[i*8 +: 8] = fwd_data[i*8 +: 8];
      end
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (0 and 3 wait states) driven by a pipelined master,
// checked by a scoreboard fed from a sequential byte-addressed memory model.
module tb_ahb_sram_slave;
  import ahb_pkg::*;

  localparam int MEM_LOG2 = 16;
  localparam int WS0 = 0;
  localparam int WS1 = 3;
  localparam logic [31:0] WINDOW = 32'd1 << (MEM_LOG2 + 2);

  typedef struct {
    bit          rd;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n        [2];
  logic        hsel         [2];
  logic        hwrite       [2];
  logic        hready       [2];
  logic        hready_force [2];
  logic        hreadyout    [2];
  logic [31:0] haddr        [2];
  logic [31:0] hwdata       [2];
  logic [31:0] hrdata       [2];
  logic [1:0]  htrans       [2];
  logic [1:0]  hresp        [2];
  logic [2:0]  hsize        [2];

  assign hready[0] = hreadyout[0] & hready_force[0];
  assign hready[1] = hreadyout[1] & hready_force[1];

  ahb_sram_slave #(.MEM_LOG2(MEM_LOG2), .WAIT_STATES(WS0), .INIT_FILE("")) dut0 (
    .HCLK(clk), .HRESETn(rst_n[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HREADY(hready[0]), .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]),
    .HRESP(hresp[0]));

  ahb_sram_slave #(.MEM_LOG2(MEM_LOG2), .WAIT_STATES(WS1), .INIT_FILE("")) dut1 (
    .HCLK(clk), .HRESETn(rst_n[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b001), .HPROT(4'b0011), .HMASTLOCK(1'b0),
    .HREADY(hready[1]), .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]),
    .HRESP(hresp[1]));

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] mdl [int];
  int   last_accept [2];

  function automatic int ws_of(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory seen as a sequence of completed transfers: erroring beats are dropped, writes merge lanes.
  function automatic exp_t model_access(input int d, input logic wr, input logic [2:0] size,
                                        input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int key;
    logic [31:0] w;
    e.rd   = !wr;
    e.chk  = 1'b0;
    e.data = 32'd0;
    e.err  = (size > 3'd2) || (size == 3'd1 && addr[0]) ||
             (size == 3'd2 && addr[1:0] != 2'b00) || (addr >= WINDOW);
    if (!e.err) begin
      key = (d << 20) | int'(addr[31:2]);
      w = mdl.exists(key) ? mdl[key] : 32'd0;
      if (wr) begin
        for (int k = 0; k < (1 << size); k++) begin
          int lane = int'(addr[1:0]) + k;
          w[lane*8 +: 8] = wdata[lane*8 +: 8];
        end
        mdl[key] = w;
      end else begin
        e.chk  = mdl.exists(key);
        e.data = w;
      end
    end
    return e;
  endfunction

  task automatic wait_ready(input int d);
    int n = 0;
    @(negedge clk);
    while (!hready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!hready[d]) begin
      errors++;
      $display("[TB] FAIL ready_timeout dut%0d: hready=%b, expected 1 within 100 cycles", d, hready[d]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d, input logic wr, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] trans, input bit track);
    if (track) begin
      exp_t e;
      e = model_access(d, wr, size, addr, wdata);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    hsel[d]   = 1'b1;
    haddr[d]  = addr;
    hwrite[d] = wr;
    hsize[d]  = size;
    htrans[d] = trans;
    wait_ready(d);
    hwdata[d] = wdata;
    last_accept[d] = cyc;
  endtask

  task automatic go_idle(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = HTRANS_IDLE;
    hwrite[d] = 1'b0;
    wait_ready(d);
  endtask

  task automatic prefill(input int d);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(d, 1'b1, HSIZE_WORD, 32'h100 + 32'(4 * i), $urandom,
                    (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1);
    end
    go_idle(d);
  endtask

  task automatic burst_timing(input int d);
    int first;
    applyStimulus(d, 1'b0, HSIZE_WORD, 32'h100, 32'd0, HTRANS_NONSEQ, 1'b1);
    first = last_accept[d];
    for (int i = 1; i < 4; i++) begin
      applyStimulus(d, 1'b0, HSIZE_WORD, 32'h100 + 32'(4 * i), 32'd0, HTRANS_SEQ, 1'b1);
    end
    go_idle(d);
    checkOutput($sformatf("burst4_cycles_dut%0d", d), 32'(cyc - first), 32'(4 * (1 + ws_of(d))));
  endtask

  task automatic random_traffic(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      logic        wr;
      int          r;
      sz = 3'($urandom_range(2, 0));
      a  = 32'h100 + 32'(4 * $urandom_range(15, 0));
      if (sz == HSIZE_BYTE) a = a + 32'($urandom_range(3, 0));
      if (sz == HSIZE_HALF) a = a + 32'(2 * $urandom_range(1, 0));
      r = int'($urandom_range(9, 0));
      if (r == 0) sz = 3'($urandom_range(7, 3));
      else if (r == 1) a = a | WINDOW;
      else if (r == 2 && sz == HSIZE_HALF) a = a | 32'd1;
      else if (r == 3 && sz == HSIZE_WORD) a = a | 32'd2;
      wr = 1'($urandom_range(1, 0));
      if ($urandom_range(6, 0) == 0) go_idle(d);
      applyStimulus(d, wr, sz, a, $urandom, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1);
    end
    go_idle(d);
  endtask

  // Monitor: follows the bus pipeline and scores each completing data phase against the queue.
  bit          in_dp   [2];
  int          low_cnt [2];
  logic [1:0]  low_resp[2];
  exp_t        mon_e;
  bit          mon_have;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        in_dp[d] = 1'b0;
      end else begin
        if (in_dp[d]) begin
          if (!hreadyout[d]) begin
            low_cnt[d]++;
            low_resp[d] = low_resp[d] | hresp[d];
          end else begin
            in_dp[d] = 1'b0;
            mon_have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
            if (!mon_have) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_completion dut%0d: queue size 0, expected >0", d);
            end else begin
              mon_e = (d == 0) ? q0.pop_front() : q1.pop_front();
              checkOutput($sformatf("hresp_dut%0d", d), 32'(hresp[d]),
                          32'(mon_e.err ? HRESP_ERROR : HRESP_OKAY));
              checkOutput($sformatf("wait_cycles_dut%0d", d), 32'(low_cnt[d]),
                          32'(mon_e.err ? 1 : ws_of(d)));
              checkOutput($sformatf("wait_resp_dut%0d", d), 32'(low_resp[d]),
                          32'(mon_e.err ? HRESP_ERROR : HRESP_OKAY));
              if (mon_e.rd && !mon_e.err && mon_e.chk) begin
                checkOutput($sformatf("hrdata_dut%0d", d), hrdata[d], mon_e.data);
              end
            end
          end
        end
        if (hsel[d] && hready[d] && htrans[d][1]) begin
          in_dp[d]    = 1'b1;
          low_cnt[d]  = 0;
          low_resp[d] = 2'b00;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time %0t reached, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = 32'd0; htrans[d] = HTRANS_IDLE;
      hwrite[d] = 1'b0; hsize[d] = HSIZE_WORD; hwdata[d] = 32'd0; hready_force[d] = 1'b1;
      last_accept[d] = 0; in_dp[d] = 1'b0; low_cnt[d] = 0; low_resp[d] = 2'b00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset_hreadyout_dut%0d", d), 32'(hreadyout[d]), 32'd1);
      checkOutput($sformatf("reset_hresp_dut%0d", d), 32'(hresp[d]), 32'(HRESP_OKAY));
      checkOutput($sformatf("reset_hrdata_dut%0d", d), hrdata[d], 32'd0);
      rst_n[d] = 1'b1;
    end
    @(posedge clk);
    #1;

    // Write then immediate read of the same word exercises forwarding.
    applyStimulus(0, 1'b1, HSIZE_WORD, 32'h100, 32'hDEADBEEF, HTRANS_NONSEQ, 1'b1);
    applyStimulus(0, 1'b0, HSIZE_WORD, 32'h100, 32'd0, HTRANS_NONSEQ, 1'b1);
    go_idle(0);
    checkOutput("fwd_word_read", hrdata[0], 32'hDEADBEEF);

    applyStimulus(0, 1'b1, HSIZE_WORD, 32'h100, 32'h11223344, HTRANS_NONSEQ, 1'b1);
    applyStimulus(0, 1'b1, HSIZE_BYTE, 32'h101, 32'h0000AA00, HTRANS_NONSEQ, 1'b1);
    applyStimulus(0, 1'b0, HSIZE_WORD, 32'h100, 32'd0, HTRANS_NONSEQ, 1'b1);
    go_idle(0);
    checkOutput("byte_merge_read", hrdata[0], 32'h1122AA44);
    applyStimulus(0, 1'b1, HSIZE_HALF, 32'h102, 32'h55660000, HTRANS_NONSEQ, 1'b1);
    applyStimulus(0, 1'b0, HSIZE_WORD, 32'h100, 32'd0, HTRANS_NONSEQ, 1'b1);
    go_idle(0);
    checkOutput("half_merge_read", hrdata[0], 32'h5566AA44);

    applyStimulus(0, 1'b1, HSIZE_HALF, 32'h103, 32'hFFFFFFFF, HTRANS_NONSEQ, 1'b1);
    applyStimulus(0, 1'b1, 3'b011, 32'h100, 32'h01010101, HTRANS_NONSEQ, 1'b1);
    applyStimulus(0, 1'b1, HSIZE_WORD, WINDOW, 32'h02020202, HTRANS_NONSEQ, 1'b1);
    applyStimulus(0, 1'b0, HSIZE_WORD, 32'h100, 32'd0, HTRANS_NONSEQ, 1'b1);
    go_idle(0);
    checkOutput("after_errors_read", hrdata[0], 32'h5566AA44);

    prefill(0);

    // Another slave holds HREADY low: the request must not be taken.
    hready_force[0] = 1'b0;
    hsel[0] = 1'b1; htrans[0] = HTRANS_NONSEQ; hwrite[0] = 1'b1;
    hsize[0] = HSIZE_WORD; haddr[0] = 32'h120; hwdata[0] = 32'hBADC0DE5;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("hready_low_hreadyout_%0d", i), 32'(hreadyout[0]), 32'd1);
    end
    hsel[0] = 1'b0; htrans[0] = HTRANS_IDLE; hwrite[0] = 1'b0;
    hready_force[0] = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, HSIZE_WORD, 32'h120, 32'd0, HTRANS_NONSEQ, 1'b1);
    go_idle(0);

    burst_timing(0);
    random_traffic(0, 80);

    // Reset in the middle of a waited write drops that write.
    applyStimulus(1, 1'b1, HSIZE_WORD, 32'h10, 32'h12345678, HTRANS_NONSEQ, 1'b1);
    go_idle(1);
    applyStimulus(1, 1'b1, HSIZE_WORD, 32'h10, 32'hCAFEF00D, HTRANS_NONSEQ, 1'b0);
    hsel[1] = 1'b0; htrans[1] = HTRANS_IDLE; hwrite[1] = 1'b0;
    @(posedge clk);
    #3;
    rst_n[1] = 1'b0;
    #1;
    checkOutput("midwait_reset_hreadyout", 32'(hreadyout[1]), 32'd1);
    checkOutput("midwait_reset_hresp", 32'(hresp[1]), 32'(HRESP_OKAY));
    checkOutput("midwait_reset_hrdata", hrdata[1], 32'd0);
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, HSIZE_WORD, 32'h10, 32'd0, HTRANS_NONSEQ, 1'b1);
    go_idle(1);
    checkOutput("dropped_write_read", hrdata[1], 32'h12345678);

    prefill(1);
    burst_timing(1);
    random_traffic(1, 60);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
